// File: rtl/rob_commit_ctrl.sv
// -----------------------------------------------------------------------------
// rob_commit_ctrl
//
// Purpose:
//   In-order commit controller sitting at the head of a reorder buffer.
//   Retires completed ALU ops in the same cycle, with a combinational dequeue
//   and register write. Holds a store at the head until the data cache
//   acknowledges it. On a mispredicted branch it raises a one-cycle flush and
//   then drains for DRAIN_CYCLES cycles before committing again.
//
// Parameters:
//   DRAIN_CYCLES  1..15   idle cycles spent in DRAIN after a flush
//   TIMEOUT       1..255  STORE_WAIT cycles without ack before timeout_o sets
//
// Configuration macro:
//   COMMIT_PERF_CNT_EN    when defined, commit_cnt_o / flush_cnt_o count
//                         dequeues / flushes (wrapping); otherwise tied to 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   head_valid, head_done    ROB head entry is valid / has completed
//   head_is_store            head entry is a store
//   head_mispredict          head entry is a mispredicted branch
//   head_regf_we             head entry writes a destination register
//   head_rd_addr/_data       destination register index / value
//   head_pc_new              redirect target of a mispredicted head
//   store_ack                data cache accepted the outstanding store
//   dequeue_o                pop the ROB head this cycle (combinational)
//   regf_we_o, regf_rd_*_o   architectural register write (combinational)
//   store_req_o              registered store commit request
//   flush_o, flush_pc_o      one-cycle pipeline flush and redirect PC
//   busy_o                   controller is not in COMMIT
//   timeout_o                sticky store acknowledge timeout
//   commit_cnt_o, flush_cnt_o performance counters
// -----------------------------------------------------------------------------
module rob_commit_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        head_valid,
  input  logic        head_done,
  input  logic        head_is_store,
  input  logic        head_mispredict,
  input  logic        head_regf_we,
  input  logic [4:0]  head_rd_addr,
  input  logic [31:0] head_rd_data,
  input  logic [31:0] head_pc_new,
  input  logic        store_ack,
  output logic        dequeue_o,
  output logic        regf_we_o,
  output logic [4:0]  regf_rd_addr_o,
  output logic [31:0] regf_rd_data_o,
  output logic        store_req_o,
  output logic        flush_o,
  output logic [31:0] flush_pc_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic [31:0] commit_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_COMMIT     = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_DRAIN      = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_LOAD   = 4'(DRAIN_CYCLES);
  // Wait-counter value seen during the last permitted cycle without an ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_r;
  logic        store_req_r;
  logic        timeout_r;
  logic [7:0]  wait_cnt_r;
  logic [3:0]  drain_cnt_r;

  logic        head_ready_s;
  logic        commit_s;
  logic        store_start_s;
  logic        store_done_s;
  logic        flush_s;
  logic        dequeue_s;
  logic        regf_we_s;
  logic [31:0] flush_pc_s;

  // Combinational commit decisions. Every strobe is qualified by !rst so
  // nothing leaks out while reset is held, even before state is defined.
  assign head_ready_s  = head_valid & head_done;
  assign commit_s      = ~rst & (state_r == ST_COMMIT) & head_ready_s & ~head_is_store;
  assign store_start_s = ~rst & (state_r == ST_COMMIT) & head_ready_s & head_is_store;
  // An ack only retires the store if the head is still present; a stray ack
  // with an empty head is ignored and the request stays up.
  assign store_done_s  = ~rst & (state_r == ST_STORE_WAIT) & store_ack & head_valid;
  assign flush_s       = commit_s & head_mispredict;
  assign dequeue_s     = commit_s | store_done_s;
  // x0 is hardwired to zero, so never write it.
  assign regf_we_s     = commit_s & head_regf_we & (head_rd_addr != 5'd0);
  assign flush_pc_s    = flush_s ? head_pc_new : 32'h0000_0000;

  // Commit FSM with its registered store request, timeout flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_COMMIT;
      store_req_r <= 1'b0;
      timeout_r   <= 1'b0;
      wait_cnt_r  <= 8'd0;
      drain_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_COMMIT: begin
          if (store_start_s) begin
            state_r     <= ST_STORE_WAIT;
            store_req_r <= 1'b1;
            wait_cnt_r  <= 8'd0;
          end else if (flush_s) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= DRAIN_LOAD;
          end else begin
            state_r     <= ST_COMMIT;
          end
        end
        ST_STORE_WAIT: begin
          if (store_done_s) begin
            state_r     <= ST_COMMIT;
            store_req_r <= 1'b0;
            wait_cnt_r  <= 8'd0;
          end else begin
            // Saturate so a very long stall cannot wrap back below TIMEOUT.
            if (wait_cnt_r != 8'hFF) begin
              wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
              wait_cnt_r <= wait_cnt_r;
            end
            if (wait_cnt_r >= TIMEOUT_LAST) begin
              timeout_r <= 1'b1;
            end else begin
              timeout_r <= timeout_r;
            end
          end
        end
        ST_DRAIN: begin
          // Counter value 1 is the final drain cycle; it reaches 0 on exit.
          if (drain_cnt_r <= 4'd1) begin
            state_r     <= ST_COMMIT;
            drain_cnt_r <= 4'd0;
          end else begin
            drain_cnt_r <= drain_cnt_r - 4'd1;
          end
        end
        default: begin
          state_r     <= ST_COMMIT;
          store_req_r <= 1'b0;
          wait_cnt_r  <= 8'd0;
          drain_cnt_r <= 4'd0;
        end
      endcase
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] commit_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running, wrapping event counters for dequeues and flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else begin
      if (dequeue_s) begin
        commit_cnt_r <= commit_cnt_r + 32'd1;
      end else begin
        commit_cnt_r <= commit_cnt_r;
      end
      if (flush_s) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign commit_cnt_o = commit_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;
`else
  assign commit_cnt_o = 32'd0;
  assign flush_cnt_o  = 32'd0;
`endif

  assign dequeue_o      = dequeue_s;
  assign regf_we_o      = regf_we_s;
  assign regf_rd_addr_o = head_rd_addr;
  assign regf_rd_data_o = head_rd_data;
  assign store_req_o    = store_req_r;
  assign flush_o        = flush_s;
  assign flush_pc_o     = flush_pc_s;
  assign busy_o         = (state_r != ST_COMMIT);
  assign timeout_o      = timeout_r;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl (DRAIN_CYCLES=2, TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid, head_done, head_is_store, head_mispredict, head_regf_we;
  logic [4:0]  head_rd_addr;
  logic [31:0] head_rd_data, head_pc_new;
  logic        store_ack;
  logic        dequeue_o, regf_we_o, store_req_o, flush_o, busy_o, timeout_o;
  logic [4:0]  regf_rd_addr_o;
  logic [31:0] regf_rd_data_o, flush_pc_o, commit_cnt_o, flush_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.DRAIN_CYCLES(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_done(head_done), .head_is_store(head_is_store),
    .head_mispredict(head_mispredict), .head_regf_we(head_regf_we),
    .head_rd_addr(head_rd_addr), .head_rd_data(head_rd_data),
    .head_pc_new(head_pc_new), .store_ack(store_ack),
    .dequeue_o(dequeue_o), .regf_we_o(regf_we_o), .regf_rd_addr_o(regf_rd_addr_o),
    .regf_rd_data_o(regf_rd_data_o), .store_req_o(store_req_o), .flush_o(flush_o),
    .flush_pc_o(flush_pc_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .commit_cnt_o(commit_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic        valid, done, store, mis, we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ack;
    logic        exp_deq, exp_we;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic s, input logic m,
                       input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input logic [31:0] pc, input logic ack);
    head_valid = v; head_done = d; head_is_store = s; head_mispredict = m;
    head_regf_we = we; head_rd_addr = rd; head_rd_data = data;
    head_pc_new = pc; store_ack = ack;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Advance one clock: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sreq_cycles;
    int exp_commits;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7,  32'h0000_0077, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0033, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  32'h0000_0099, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1};

    // Reset: strobes stay low even with a done mispredicting head present.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1, 32'h6000_0040, 1'b1);
    #1;
    check("rst_deq_t0", {31'd0, dequeue_o}, 32'd0);
    check("rst_flush_t0", {31'd0, flush_o}, 32'd0);
    @(negedge clk);
    step();
    #1;
    check("rst_deq", {31'd0, dequeue_o}, 32'd0);
    check("rst_we", {31'd0, regf_we_o}, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_flush_pc", flush_pc_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_sreq", {31'd0, store_req_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_commit_cnt", commit_cnt_o, 32'd0);
    check("rst_flush_cnt", flush_cnt_o, 32'd0);

    // Table-driven COMMIT-state vectors; none of these leaves COMMIT.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].done, vecs[i].store, vecs[i].mis, vecs[i].we,
            vecs[i].rd, vecs[i].data, 32'h1111_0000, vecs[i].ack);
      #1;
      check($sformatf("vec%0d_deq", i), {31'd0, dequeue_o}, {31'd0, vecs[i].exp_deq});
      check($sformatf("vec%0d_we", i), {31'd0, regf_we_o}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_flush", i), {31'd0, flush_o}, 32'd0);
      check($sformatf("vec%0d_busy", i), {31'd0, busy_o}, 32'd0);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_addr", i), {27'd0, regf_rd_addr_o}, {27'd0, vecs[i].rd});
        check($sformatf("vec%0d_data", i), regf_rd_data_o, vecs[i].data);
      end
    end
    @(negedge clk);
    idle();

    // Store acked 3 cycles after it reaches a done head.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check("st_issue_deq", {31'd0, dequeue_o}, 32'd0);
    check("st_issue_sreq", {31'd0, store_req_o}, 32'd0);
    sreq_cycles = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      store_ack = (k == 3);
      #1;
      if (store_req_o === 1'b1) sreq_cycles++;
      check($sformatf("st_wait%0d_busy", k), {31'd0, busy_o}, 32'd1);
      check($sformatf("st_wait%0d_deq", k), {31'd0, dequeue_o}, {31'd0, (k == 3)});
      check($sformatf("st_wait%0d_we", k), {31'd0, regf_we_o}, 32'd0);
    end
    step();
    idle();
    #1;
    check("st_sreq_cycles", sreq_cycles, 32'd3);
    check("st_after_sreq", {31'd0, store_req_o}, 32'd0);
    check("st_after_busy", {31'd0, busy_o}, 32'd0);

    // Mispredict: one flush cycle, then two drain cycles ignoring a done head.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_00AB, 32'h6000_0040, 1'b0);
    #1;
    check("mp_deq", {31'd0, dequeue_o}, 32'd1);
    check("mp_we", {31'd0, regf_we_o}, 32'd1);
    check("mp_flush", {31'd0, flush_o}, 32'd1);
    check("mp_flush_pc", flush_pc_o, 32'h6000_0040);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0044, 32'h0, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      #1;
      check($sformatf("drain%0d_deq", k), {31'd0, dequeue_o}, 32'd0);
      check($sformatf("drain%0d_we", k), {31'd0, regf_we_o}, 32'd0);
      check($sformatf("drain%0d_flush", k), {31'd0, flush_o}, 32'd0);
      check($sformatf("drain%0d_busy", k), {31'd0, busy_o}, 32'd1);
      step();
    end
    #1;
    check("drain_exit_deq", {31'd0, dequeue_o}, 32'd1);
    check("drain_exit_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    idle();

    // Store never acked: timeout after 4 wait cycles, cleared by reset.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      #1;
      check($sformatf("to_wait%0d", k), {31'd0, timeout_o}, {31'd0, (k == 5)});
      check($sformatf("to_sreq%0d", k), {31'd0, store_req_o}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    store_ack = 1'b1;
    #1;
    check("to_rst_deq", {31'd0, dequeue_o}, 32'd0);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("to_rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("to_rst_busy", {31'd0, busy_o}, 32'd0);
    check("to_rst_sreq", {31'd0, store_req_o}, 32'd0);

    // Ten commits including two mispredicts, from a clean reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, (i == 3 || i == 7), 1'b1, 5'(i + 1), 32'(i), 32'h100, 1'b0);
      #1;
      check($sformatf("perf%0d_deq", i), {31'd0, dequeue_o}, 32'd1);
      if (i == 3 || i == 7) begin
        @(negedge clk);
        idle();
        @(negedge clk);
      end
    end
    @(negedge clk);
    idle();
    #1;
`ifdef COMMIT_PERF_CNT_EN
    exp_commits = 10;
    check("perf_commit_cnt", commit_cnt_o, 32'(exp_commits));
    check("perf_flush_cnt", flush_cnt_o, 32'd2);
`else
    exp_commits = 0;
    check("perf_commit_cnt", commit_cnt_o, 32'(exp_commits));
    check("perf_flush_cnt", flush_cnt_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 1, range 1-15: idle cycles in DRAIN after a flush.
REQ-002 SHALL have parameter TIMEOUT, default 255, range 1-255: STORE_WAIT cycles before error.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 head_valid  input  1  ROB head entry valid.
REQ-006 head_done  input  1  ROB head status == done.
REQ-007 head_is_store  input  1  head is a store.
REQ-008 head_mispredict  input  1  head is a branch with br_en != prediction.
REQ-009 head_regf_we, head_rd_addr, head_rd_data  input  1/5/32  head writeback info.
REQ-010 head_pc_new  input  32  redirect target of head.
REQ-011 store_ack  input  1  data cache accepted the committed store.
REQ-012 dequeue_o  output  1  pops the ROB head this cycle.
REQ-013 regf_we_o, regf_rd_addr_o, regf_rd_data_o  output  1/5/32  architectural register write.
REQ-014 store_req_o  output  1  store commit request, registered.
REQ-015 flush_o, flush_pc_o  output  1/32  one-cycle flush pulse and redirect PC.
REQ-016 busy_o  output  1  FSM not in COMMIT; timeout_o  output  1  sticky store timeout.
REQ-017 commit_cnt_o, flush_cnt_o  output  32/32  performance counters.

Function
REQ-018 FSM states SHALL be COMMIT, STORE_WAIT, DRAIN; reset state COMMIT.
REQ-019 COMMIT, head_valid&head_done&!head_is_store&!head_mispredict: dequeue_o=1 same cycle (combinational); regf_we_o=head_regf_we&(head_rd_addr!=0); rd addr/data pass through.
REQ-020 COMMIT, valid&done&head_mispredict: dequeue_o=1, regf write as REQ-019, flush_o=1, flush_pc_o=head_pc_new same cycle; next state DRAIN.
REQ-021 COMMIT, valid&done&head_is_store: no dequeue; store_req_o=1 from next cycle; next state STORE_WAIT.
REQ-022 STORE_WAIT: store_req_o held 1; on store_ack: dequeue_o=1 same cycle, store_req_o=0 next cycle, next state COMMIT.
REQ-023 STORE_WAIT: wait counter increments per cycle without ack; at TIMEOUT set timeout_o (sticky until rst), stay in STORE_WAIT.
REQ-024 DRAIN: no dequeue, no regf write, no flush; down-counter loaded with DRAIN_CYCLES on entry; exits to COMMIT when it reaches 0.
REQ-025 head_valid=0 or head_done=0 in COMMIT: all strobes 0, stay.
REQ-026 At most one dequeue per cycle; dequeue_o never asserted with head_valid=0.
REQ-027 store_ack outside STORE_WAIT SHALL be ignored.
REQ-028 flush_o SHALL never be asserted two consecutive cycles.
REQ-029 busy_o=1 in STORE_WAIT and DRAIN.

Reset
REQ-030 rst in any state (incl. mid-STORE_WAIT) SHALL return to COMMIT next edge; store_req_o, timeout_o, counters, wait/drain counters =0.
REQ-031 During rst-asserted cycles all combinational strobes (dequeue_o, regf_we_o, flush_o) SHALL be 0; flush_pc_o=0.

Configuration
REQ-032 Macro COMMIT_PERF_CNT_EN defined: commit_cnt_o increments per dequeue_o, flush_cnt_o per flush_o, both wrap 2^32-1->0.
REQ-033 Macro undefined: counters not implemented; commit_cnt_o and flush_cnt_o tied 0.

Verification
REQ-034 ALU head done, rd=5, data=0x1234 -> same cycle dequeue_o=1, regf_we_o=1, addr 5, data 0x1234.
REQ-035 Head done, rd=0, regf_we=1 -> dequeue_o=1, regf_we_o=0.
REQ-036 Store head done, store_ack 3 cycles later -> store_req_o high 3 cycles, dequeue_o on ack cycle only, busy_o high meanwhile.
REQ-037 Mispredict head, pc_new=0x6000_0040, DRAIN_CYCLES=2 -> flush_o 1 cycle with pc 0x6000_0040, then 2 cycles no dequeue despite done head.
REQ-038 Store never acked, TIMEOUT=4 -> timeout_o=1 after 4 wait cycles; rst -> COMMIT, timeout_o=0.
REQ-039 With COMMIT_PERF_CNT_EN: 10 commits incl. 2 mispredicts -> commit_cnt_o=10, flush_cnt_o=2; without macro both 0.
